// File: rtl/bin_capture_fifo_pkg.sv
// Shared types and constants for the bin capture FIFO: FSM state encoding and
// output word layout.
package bin_capture_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DOUT_W = 16;
  localparam int TAG_W  = 8;
  localparam int CNT8_W = 8;

endpackage

// File: rtl/bin_capture_fifo_if.sv
// Control, counter and drain-side signals of bin_capture_fifo. The slave modport
// is the capture block; the master modport is whoever drives it.
interface bin_capture_fifo_if
  import bin_capture_fifo_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int FIFO_AW = 4
);

  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   count_in;
  logic               count_clr;
  logic               bin_end;
  logic               busy;
  logic [DOUT_W-1:0]  dout;
  logic               dout_valid;
  logic               dout_ready;
  logic [FIFO_AW:0]   fifo_level;
  logic               overflow;

  modport master (
    output start, abort, count_in, dout_ready,
    input  count_clr, bin_end, busy, dout, dout_valid, fifo_level, overflow
  );

  modport slave (
    input  start, abort, count_in, dout_ready,
    output count_clr, bin_end, busy, dout, dout_valid, fifo_level, overflow
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO, depth 2**AW. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: the storage array has no reset; only pointers and level carry state
  // that matters after reset, and leaving the array alone keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/bin_capture_fifo.sv
// Time-bin generator and count capture FIFO behind the PMT photon counter.
// Define BIN_TAG_EN to store bin_idx[7:0] with each count in dout[15:8].
module bin_capture_fifo
  import bin_capture_fifo_pkg::*;
#(
  parameter int BIN_CYCLES = 250000,
  parameter int NUM_BINS   = 200,
  parameter int CNT_W      = 8,
  parameter int FIFO_AW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  bin_capture_fifo_if.slave bus
);

  localparam int               TMR_W    = $clog2(BIN_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIN_CYCLES - 1);
  localparam logic [15:0]      LAST_BIN = 16'(NUM_BINS - 1);
`ifdef BIN_TAG_EN
  localparam int FIFO_W = TAG_W + CNT8_W;
`else
  localparam int FIFO_W = CNT8_W;
`endif

  state_e             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [15:0]        bin_idx_q;
  logic               overflow_q;

  logic [CNT_W-1:0]   count_raw;
  logic [CNT8_W-1:0]  count8;
  logic [FIFO_W-1:0]  wdata;
  logic [FIFO_W-1:0]  rdata;
  logic               capture;
  logic               last_bin;
  logic               pop;
  logic               full;
  logic               empty;
  logic               drop;
  logic [FIFO_AW:0]   level;

  assign count_raw = bus.count_in;
  assign count8    = CNT8_W'(count_raw);

  // abort wins over a coincident bin boundary: no strobe, no clear, no push
  assign capture  = (state_q == ST_RUN) && (timer_q == TMR_LAST) && !bus.abort;
  assign last_bin = (NUM_BINS != 0) && (bin_idx_q == LAST_BIN);
  assign pop      = !empty && bus.dout_ready;
  assign drop     = capture && full && !pop;

`ifdef BIN_TAG_EN
  assign wdata    = {bin_idx_q[TAG_W-1:0], count8};
  assign bus.dout = empty ? '0 : rdata;
`else
  assign wdata    = count8;
  assign bus.dout = empty ? '0 : {{(DOUT_W-FIFO_W){1'b0}}, rdata};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bin_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (bus.start) state_q <= ST_ARM;
        end
        ST_ARM: begin
          timer_q    <= '0;
          bin_idx_q  <= '0;
          overflow_q <= 1'b0;
          state_q    <= bus.abort ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
          end else if (capture) begin
            timer_q   <= '0;
            bin_idx_q <= bin_idx_q + 16'd1;
            if (drop)     overflow_q <= 1'b1;
            if (last_bin) state_q    <= ST_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo_fwft #(
    .W  (FIFO_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (capture),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign bus.count_clr  = (state_q == ST_ARM) || capture;
  assign bus.bin_end    = capture;
  assign bus.busy       = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign bus.dout_valid = !empty;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_bin_capture_fifo.sv
// Bench for bin_capture_fifo: a fixed-length instance (NUM_BINS=4) and a free-run
// instance (NUM_BINS=0) share stimulus; each is compared every cycle to a model.
module tb_bin_capture_fifo;

  localparam int BC      = 10;
  localparam int CNT_W   = 8;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 1 << FIFO_AW;
`ifdef BIN_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic             start      = 1'b0;
  logic             abort      = 1'b0;
  logic             dout_ready = 1'b0;
  logic [CNT_W-1:0] count_in   = '0;

  int total = 0;
  int bad   = 0;

  logic [15:0] o_dout  [2];
  logic [4:0]  o_level [2];
  logic        o_busy  [2];
  logic        o_clr   [2];
  logic        o_end   [2];
  logic        o_valid [2];
  logic        o_ovf   [2];

  logic [15:0] exp_tag [4] = '{16'h0003, 16'h0105, 16'h0200, 16'h03FF};
  logic [15:0] exp_raw [4] = '{16'h0003, 16'h0005, 16'h0000, 16'h00FF};
  logic [7:0]  ramp    [4] = '{8'd3, 8'd5, 8'd0, 8'd255};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_chk
    localparam int NB = (g == 0) ? 4 : 0;

    bin_capture_fifo_if #(.CNT_W(CNT_W), .FIFO_AW(FIFO_AW)) bus ();

    assign bus.start      = start;
    assign bus.abort      = abort;
    assign bus.count_in   = count_in;
    assign bus.dout_ready = dout_ready;

    bin_capture_fifo #(
      .BIN_CYCLES (BC),
      .NUM_BINS   (NB),
      .CNT_W      (CNT_W),
      .FIFO_AW    (FIFO_AW)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign o_dout[g]  = bus.dout;
    assign o_level[g] = bus.fifo_level;
    assign o_busy[g]  = bus.busy;
    assign o_clr[g]   = bus.count_clr;
    assign o_end[g]   = bus.bin_end;
    assign o_valid[g] = bus.dout_valid;
    assign o_ovf[g]   = bus.overflow;

    // age: cycles since the ARM cycle (0 = ARM), -1 when idle or done
    int          age     = -1;
    bit          in_done = 1'b0;
    bit          ovf     = 1'b0;
    logic [15:0] q [$];

    always @(negedge clk) begin
      bit          cap;
      bit          last_b;
      bit          pop;
      bit          nxt_done;
      int          bin;
      logic [15:0] ent;
      logic [15:0] e_dout;
      string       nm;
      nm = (g == 0) ? "a" : "f";
      if (reset) begin
        age     = -1;
        in_done = 1'b0;
        ovf     = 1'b0;
        q.delete();
      end
      cap    = !reset && (age > 0) && ((age % BC) == 0) && !abort;
      bin    = age / BC - 1;
      last_b = cap && (NB != 0) && (bin == NB - 1);
      e_dout = (q.size() > 0) ? q[0] : 16'h0000;
      check({nm, ".busy"},       bus.busy,       age >= 0);
      check({nm, ".count_clr"},  bus.count_clr,  (age == 0) || cap);
      check({nm, ".bin_end"},    bus.bin_end,    cap);
      check({nm, ".dout_valid"}, bus.dout_valid, q.size() > 0);
      check({nm, ".dout"},       bus.dout,       e_dout);
      check({nm, ".fifo_level"}, bus.fifo_level, q.size());
      check({nm, ".overflow"},   bus.overflow,   ovf);
      if (!reset) begin
        pop = (q.size() > 0) && dout_ready;
        if (age == 0) ovf = 1'b0;
        if (pop) void'(q.pop_front());
        if (cap) begin
          ent = {TAG_EN ? 8'(bin) : 8'h00, count_in};
          if (q.size() < DEPTH) q.push_back(ent);
          else ovf = 1'b1;
        end
        nxt_done = 1'b0;
        if (age >= 0) begin
          if (abort) age = -1;
          else if (last_b) begin
            age      = -1;
            nxt_done = 1'b1;
          end else age++;
        end else if (!in_done && start) begin
          age = 0;
        end
        in_done = nxt_done;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_abort();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    step();
    dout_ready = 1'b1;
    #2;
    while ((o_valid[0] || o_valid[1]) && n < 64) begin
      step();
      #2;
      n++;
    end
    check("drain_done", o_valid[0] | o_valid[1], 1'b0);
    step();
    dout_ready = 1'b0;
  endtask

  // one complete 4-bin run of instance a; bin b samples count base+b
  task automatic run_a(input logic [7:0] base);
    step(); start = 1'b1;
    step(); start = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int t = 0; t < BC; t++) begin
        step();
        count_in = base + 8'(b);
      end
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncap;
    int k;
    logic [15:0] exp_e;

    // reset state
    step(); step(); #2;
    check("rst_busy",  o_busy[0],  1'b0);
    check("rst_valid", o_valid[0], 1'b0);
    check("rst_level", o_level[0], 5'd0);
    check("rst_dout",  o_dout[0],  16'h0000);
    step(); reset = 1'b0;

    // basic run: counts 3,5,0,255
    step(); start = 1'b1;
    step(); start = 1'b0;
    #2;
    check("arm_clr",  o_clr[0],  1'b1);
    check("arm_busy", o_busy[0], 1'b1);
    for (int b = 0; b < 4; b++)
      for (int t = 0; t < BC; t++) begin
        step();
        count_in = ramp[b];
        #2;
        if (t == BC - 1) check("basic_bin_end_hi", o_end[0], 1'b1);
        if (t == 0)      check("basic_bin_end_lo", o_end[0], 1'b0);
      end
    step(); #2;
    check("done_busy", o_busy[0], 1'b0);
    check("done_clr",  o_clr[0],  1'b0);
    step(); #2;
    check("basic_level", o_level[0], 5'd4);
    check("basic_ovf",   o_ovf[0],   1'b0);
    pulse_abort();
    step();
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("basic_dout", o_dout[0], TAG_EN ? exp_tag[i] : exp_raw[i]);
      step();
    end
    #2;
    check("basic_empty", o_valid[0], 1'b0);
    drain();

    // backpressure: 20 bins into a 16-deep FIFO
    for (int r = 0; r < 4; r++) run_a(8'(r * 4));
    #2;
    check("bp_level16", o_level[0], 5'd16);
    check("bp_ovf0",    o_ovf[0],   1'b0);
    run_a(8'd16);
    #2;
    check("bp_level_hold", o_level[0], 5'd16);
    check("bp_ovf1",       o_ovf[0],   1'b1);
    pulse_abort();
    step();
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #2;
      exp_e = {TAG_EN ? 8'(i % 4) : 8'h00, 8'(i)};
      check("bp_drain", o_dout[0], exp_e);
      step();
    end
    drain();

    // full FIFO with a pop on the capture cycle
    for (int r = 0; r < 4; r++) run_a(8'(r));
    step(); start = 1'b1;
    step(); start = 1'b0;
    for (int t = 0; t < BC; t++) begin
      step();
      count_in = 8'hA5;
      if (t == BC - 1) begin
        dout_ready = 1'b1;
        #2;
        check("fp_bin_end", o_end[0],   1'b1);
        check("fp_level",   o_level[0], 5'd16);
      end
    end
    step();
    dout_ready = 1'b0;
    #2;
    check("fp_level_after", o_level[0], 5'd16);
    check("fp_ovf",         o_ovf[0],   1'b0);
    pulse_abort();
    drain();

    // abort at timer 6 of bin 2
    step(); start = 1'b1;
    step(); start = 1'b0;
    for (int t = 0; t < 2 * BC; t++) begin
      step();
      count_in = 8'(t);
    end
    for (int t = 0; t < 7; t++) begin
      step();
      if (t == 6) abort = 1'b1;
    end
    step();
    abort = 1'b0;
    #2;
    check("abort_busy",  o_busy[0],  1'b0);
    check("abort_level", o_level[0], 5'd2);
    k = 0;
    for (int t = 0; t < 15; t++) begin
      step(); #2;
      if (o_clr[0]) k++;
    end
    check("abort_no_clr", k, 0);
    drain();

    // asynchronous reset mid-run with 3 entries held
    step(); start = 1'b1;
    step(); start = 1'b0;
    for (int t = 0; t < 35; t++) begin
      step();
      count_in = 8'(t + 100);
    end
    #2;
    check("rr_level_pre", o_level[0], 5'd3);
    reset = 1'b1;
    #1;
    check("rr_busy",  o_busy[0],  1'b0);
    check("rr_clr",   o_clr[0],   1'b0);
    check("rr_end",   o_end[0],   1'b0);
    check("rr_valid", o_valid[0], 1'b0);
    check("rr_level", o_level[0], 5'd0);
    check("rr_dout",  o_dout[0],  16'h0000);
    check("rr_ovf",   o_ovf[0],   1'b0);
    step(); step();
    reset = 1'b0;
    run_a(8'h40);
    #2;
    check("rr_rerun_level", o_level[0], 5'd4);
    check("rr_rerun_dout",  o_dout[0],  16'h0040);
    pulse_abort();
    drain();

    // free-run instance past 256 bins, tag wrap
    dout_ready = 1'b1;
    step(); start = 1'b1;
    step(); start = 1'b0;
    ncap = 0;
    k    = 0;
    for (int i = 1; i <= 260 * BC; i++) begin
      step();
      count_in = 8'(i);
      #2;
      if (o_end[1]) ncap++;
      if (o_valid[1]) begin
        if (k == 255) check("fr_tag_ff", o_dout[1][15:8], TAG_EN ? 8'hFF : 8'h00);
        if (k == 256) check("fr_tag_00", o_dout[1][15:8], 8'h00);
        k++;
      end
    end
    check("fr_ncap", ncap, 260);
    check("fr_busy", o_busy[1], 1'b1);
    pulse_abort();
    drain();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      start      = ($urandom_range(0, 19) == 0);
      abort      = ($urandom_range(0, 149) == 0);
      dout_ready = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                        : ($urandom_range(0, 3) != 0);
      count_in   = 8'($urandom);
    end
    start = 1'b0;
    pulse_abort();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
